// File: rtl/async_transmitter.sv
// async_transmitter: byte FIFO feeding an 8N1/8N2 UART serialiser with its
// own integer baud divider. TxD is a flop output that lags the FSM state by
// one clock, which places the first start-bit clock two edges after a write
// into an empty FIFO.
module async_transmitter #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          TxD_start,
  input  logic [7:0]                    TxD_data,
  output logic                          TxD_ready,
  output logic                          TxD,
  output logic                          TxD_busy,
  output logic                          TxD_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    dbg_state_o
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [2:0]    STOP_M1 = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_LV = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  // Write port handshake: a byte is taken on any rising edge where
  // TxD_start=1 and TxD_ready=1; TxD_ready depends only on FIFO occupancy,
  // so a pop on the same edge never admits a write into a full FIFO.

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q, tx_d;
  logic            pop, push, fifo_empty, fifo_full, bit_end;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q;

  assign fifo_empty   = (level_q == '0);
  assign fifo_full    = (level_q == FULL_LV);
  assign push         = TxD_start & ~fifo_full;
  assign bit_end      = (baud_q == DIV_M1);

  assign TxD_ready    = ~fifo_full;
  assign TxD_overflow = TxD_start & fifo_full;
  assign TxD          = tx_q;
  assign TxD_busy     = (state_q != IDLE) | ~fifo_empty;
  assign fifo_level   = level_q;
  assign dbg_state_o  = state_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_q == 3'd7) state_d = STOP;
      STOP:  if (bit_end && bit_q == STOP_M1) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: FIFO pop request and the next line level
  always_comb begin
    pop  = 1'b0;
    tx_d = 1'b1;
    case (state_q)
      IDLE:  pop = ~fifo_empty;
      START: tx_d = 1'b0;
      DATA:  tx_d = shift_q[0];
      STOP:  pop = bit_end & (bit_q == STOP_M1) & ~fifo_empty;
      default: tx_d = 1'b1;
    endcase
  end

  // Baud counter: parked at 0 when idle, restarted on every pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          baud_q <= '0;
    else if (state_q == IDLE || pop)     baud_q <= '0;
    else if (bit_end)                    baud_q <= '0;
    else                                 baud_q <= baud_q + 1'b1;
  end

  // Bit index within DATA (0..7) or STOP (0..STOP_BITS-1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          bit_q <= '0;
    else if (state_d != state_q)                         bit_q <= '0;
    else if (bit_end && (state_q == DATA || state_q == STOP)) bit_q <= bit_q + 1'b1;
  end

  // Shift register: loaded on pop, shifted right after each data bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             shift_q <= '0;
    else if (pop)                           shift_q <= mem_q[rd_ptr_q];
    else if (state_q == DATA && bit_end)    shift_q <= {1'b0, shift_q[7:1]};
  end

  // Registered line output; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= 1'b1;
    else        tx_q <= tx_d;
  end

  // FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= TxD_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
